ad_trig_capture: RTL

AD_TRIG_CAPTURE -- requirements
Module: ad_trig_capture

---
 rtl/ad_trig_capture.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ad_trig_capture.sv
// ---------------------------------------------------------------------------
// ad_trig_capture
//
// Captures AD samples into an external buffer after a level-crossing trigger.
// The block is armed by a pulse. It then watches consecutive samples for a
// rising or falling crossing of trig_level. The triggering sample is written
// at address 0, and the following cap_len samples go to addresses 1..cap_len.
// The block then sits in DONE until it is re-armed or aborted.
//
// Optional feature (build macro CAP_OTR_CLAMP_EN):
//   defined   : a written sample flagged out-of-range is clamped to
//               all-ones (MSB set) or all-zeros (MSB clear)
//   undefined : raw ad_data is written
//   Triggering always uses raw ad_data. otr_cnt counts in both builds.
//
// Parameters:
//   AW  capture buffer address width (depth 2^AW)
//   DW  AD sample width
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   smp_en      one-cycle strobe qualifying ad_data / ad_otr
//   ad_data     AD sample
//   ad_otr      out-of-range flag for the current sample
//   arm         pulse, starts a trigger search (from IDLE or DONE only)
//   abort       pulse, cancels any capture (wins over arm)
//   trig_level  unsigned trigger threshold
//   trig_edge   0 = rising crossing, 1 = falling crossing
//   cap_len     samples captured minus one, sampled on the trigger cycle
//   wr_en       buffer write strobe (registered, single-cycle)
//   wr_addr     buffer write address (registered)
//   wr_data     buffer write data (registered)
//   busy        high while searching for the trigger or capturing
//   done        high once the capture is complete
//   otr_cnt     saturating count of out-of-range samples written this capture
// ---------------------------------------------------------------------------
module ad_trig_capture #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smp_en,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_otr,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic [AW-1:0] cap_len,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    otr_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitTrig,
    StCapture,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [AW-1:0] len_q, len_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [7:0]    otr_cnt_q, otr_cnt_d;

  logic          trig_hit;
  logic          do_write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_val;
  logic [AW-1:0] next_addr;

  // A crossing needs a valid previous sample, so the first sample after arm
  // can only seed prev and never fires the trigger.
  always_comb begin
    trig_hit = 1'b0;
    if (prev_vld_q) begin
      if (trig_edge) begin
        trig_hit = (prev_q >= trig_level) && (ad_data < trig_level);
      end else begin
        trig_hit = (prev_q < trig_level) && (ad_data >= trig_level);
      end
    end
  end

  // Value that goes to the buffer; trigger detection above stays on raw data.
  always_comb begin
`ifdef CAP_OTR_CLAMP_EN
    if (ad_otr) begin
      write_val = {DW{ad_data[DW-1]}};
    end else begin
      write_val = ad_data;
    end
`else
    write_val = ad_data;
`endif
  end

  // wr_addr_q keeps the last written address, so the next one is always +1.
  assign next_addr = wr_addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    len_d      = len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    otr_cnt_d  = otr_cnt_q;
    do_write   = 1'b0;
    write_addr = '0;

    if (abort) begin
      // Abort suppresses any write that would have been accepted this cycle.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_d    = StWaitTrig;
            otr_cnt_d  = 8'd0;
            prev_vld_d = 1'b0;
          end
        end

        StWaitTrig: begin
          if (smp_en) begin
            prev_d     = ad_data;
            prev_vld_d = 1'b1;
            if (trig_hit) begin
              do_write   = 1'b1;
              write_addr = '0;
              // Latch the length so later cap_len changes do not disturb us.
              len_d      = cap_len;
              if (cap_len == '0) begin
                state_d = StDone;
              end else begin
                state_d = StCapture;
              end
            end
          end
        end

        StCapture: begin
          if (smp_en) begin
            do_write   = 1'b1;
            write_addr = next_addr;
            // Stop on the write that lands at len_q; depth 2^AW never wraps.
            if (next_addr == len_q) begin
              state_d = StDone;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = write_addr;
      wr_data_d = write_val;
      if (ad_otr && (otr_cnt_q != 8'hFF)) begin
        otr_cnt_d = otr_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      len_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      otr_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      len_q      <= len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      otr_cnt_q  <= otr_cnt_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign otr_cnt = otr_cnt_q;
  assign busy    = (state_q == StWaitTrig) || (state_q == StCapture);
  assign done    = (state_q == StDone);

endmodule
